// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - Y86-64 PIPE stall/bubble control with run-state FSM; optional counters via PIPE_PERF_CNT_EN
module pipe_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [1:0]       m_stat,
  input  logic [1:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             set_cc,
  output logic [1:0]       run_state,
  output logic             halted,
  output logic [1:0]       halt_code,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] loaduse_cnt,
  output logic [CNT_W-1:0] mispred_cnt,
  output logic [CNT_W-1:0] ret_cnt
);

  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [3:0] RNONE   = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_HALTED = 2'b10
  } state_t;

  state_t state;
  state_t state_nxt;

  logic lu;
  logic rt;
  logic mp;
  logic exc_m;
  logic exc_w;

  // Hazard detection terms; RNONE destinations never create a load-use dependency
  assign lu    = ((E_icode == IMRMOVQ) || (E_icode == IPOPQ)) && (E_dstM != RNONE) &&
                 ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  assign rt    = (D_icode == IRET) || (E_icode == IRET) || (M_icode == IRET);
  assign mp    = (E_icode == IJXX) && !e_Cnd;
  assign exc_m = (m_stat != 2'b00);
  assign exc_w = (W_stat != 2'b00);

  // Run-state register and halt status capture on the RUN->HALTED edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      halt_code <= 2'b00;
    end else begin
      state <= state_nxt;
      if ((state == S_RUN) && exc_w) begin
        halt_code <= W_stat;
      end
    end
  end

  // Next-state logic and per-state selection of the stage-register controls
  always_comb begin
    state_nxt = state;
    F_stall   = 1'b0;
    D_stall   = 1'b0;
    D_bubble  = 1'b0;
    E_bubble  = 1'b0;
    M_bubble  = 1'b0;
    W_stall   = 1'b0;
    set_cc    = 1'b0;
    case (state)
      S_IDLE: begin
        F_stall  = 1'b1;
        D_bubble = 1'b1;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
        if (start) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        F_stall  = lu | rt;
        D_stall  = lu;
        D_bubble = mp | (!lu & rt);
        E_bubble = mp | lu;
        M_bubble = exc_m | exc_w;
        W_stall  = exc_w;
        set_cc   = (E_icode == IOPQ) & !exc_m & !exc_w;
        if (exc_w) begin
          state_nxt = S_HALTED;
        end
      end
      S_HALTED: begin
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
        W_stall  = 1'b1;
      end
      default: begin
        F_stall   = 1'b1;
        D_bubble  = 1'b1;
        E_bubble  = 1'b1;
        M_bubble  = 1'b1;
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign run_state = state;
  assign halted    = (state == S_HALTED);

`ifdef PIPE_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Saturating event counters, advanced only while running
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt   <= '0;
      loaduse_cnt <= '0;
      mispred_cnt <= '0;
      ret_cnt     <= '0;
    end else if (state == S_RUN) begin
      if (!(&cycle_cnt)) begin
        cycle_cnt <= cycle_cnt + CNT_ONE;
      end
      if (lu && !(&loaduse_cnt)) begin
        loaduse_cnt <= loaduse_cnt + CNT_ONE;
      end
      if (mp && !(&mispred_cnt)) begin
        mispred_cnt <= mispred_cnt + CNT_ONE;
      end
      if (rt && !lu && !(&ret_cnt)) begin
        ret_cnt <= ret_cnt + CNT_ONE;
      end
    end
  end
`else
  assign cycle_cnt   = '0;
  assign loaduse_cnt = '0;
  assign mispred_cnt = '0;
  assign ret_cnt     = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed and randomized self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [3:0]    D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
  logic          e_Cnd;
  logic [1:0]    m_stat, W_stat;
  logic          F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc;
  logic [1:0]    run_state;
  logic          halted;
  logic [1:0]    halt_code;
  logic [CW-1:0] cycle_cnt, loaduse_cnt, mispred_cnt, ret_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state: 0 idle, 1 run, 2 halted
  int       m_mode;
  logic [1:0] m_hcode;
  int       m_cyc, m_lu, m_mp, m_rt;

  pipe_hazard_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
    .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
    .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
    .set_cc(set_cc), .run_state(run_state), .halted(halted),
    .halt_code(halt_code), .cycle_cnt(cycle_cnt), .loaduse_cnt(loaduse_cnt),
    .mispred_cnt(mispred_cnt), .ret_cnt(ret_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit f_lu();
    return ((E_icode == 4'h5) || (E_icode == 4'hB)) && (E_dstM != 4'hF) &&
           ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  endfunction

  function automatic bit f_rt();
    return (D_icode == 4'h9) || (E_icode == 4'h9) || (M_icode == 4'h9);
  endfunction

  function automatic bit f_mp();
    return (E_icode == 4'h7) && !e_Cnd;
  endfunction

  // expected {F_stall,D_stall,D_bubble,E_bubble,M_bubble,W_stall,set_cc}
  function automatic logic [6:0] exp_ctl();
    bit lu, rt, mp, xm, xw;
    lu = f_lu(); rt = f_rt(); mp = f_mp();
    xm = (m_stat != 0); xw = (W_stat != 0);
    if (rst || m_mode == 0) return 7'b1011100;
    if (m_mode == 2) return 7'b1101110;
    return {lu | rt, lu, mp | (!lu & rt), mp | lu, xm | xw, xw, (E_icode == 4'h6) & !xm & !xw};
  endfunction

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_hcode = 2'b00;
    m_cyc = 0; m_lu = 0; m_mp = 0; m_rt = 0;
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else if (m_mode == 0) begin
      if (start) m_mode = 1;
    end else if (m_mode == 1) begin
      m_cyc = sat(m_cyc);
      if (f_lu()) m_lu = sat(m_lu);
      if (f_mp()) m_mp = sat(m_mp);
      if (f_rt() && !f_lu()) m_rt = sat(m_rt);
      if (W_stat != 0) begin
        m_mode = 2; m_hcode = W_stat;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    int ec, el, em, er;
`ifdef PIPE_PERF_CNT_EN
    ec = m_cyc; el = m_lu; em = m_mp; er = m_rt;
`else
    ec = 0; el = 0; em = 0; er = 0;
`endif
    chk({tag, ".ctl"}, {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc}, exp_ctl());
    chk({tag, ".run_state"}, run_state, (rst ? 0 : m_mode));
    chk({tag, ".halted"}, halted, (!rst && m_mode == 2));
    chk({tag, ".halt_code"}, halt_code, m_hcode);
    chk({tag, ".cycle_cnt"}, cycle_cnt, ec);
    chk({tag, ".loaduse_cnt"}, loaduse_cnt, el);
    chk({tag, ".mispred_cnt"}, mispred_cnt, em);
    chk({tag, ".ret_cnt"}, ret_cnt, er);
  endtask

  // inputs are changed just after a negedge; the edge advances model and DUT together
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic cyc(input string tag);
    #1;
    chk_all(tag);
    tick();
  endtask

  task automatic clr();
    start = 0; D_icode = 0; E_icode = 0; M_icode = 0;
    d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF; e_Cnd = 1;
    m_stat = 0; W_stat = 0;
  endtask

  function automatic logic [3:0] pick_icode();
    logic [3:0] tbl [8];
    tbl = '{4'h0, 4'h2, 4'h5, 4'h6, 4'h7, 4'h9, 4'hB, 4'h1};
    return tbl[$urandom_range(0, 7)];
  endfunction

  function automatic logic [3:0] pick_reg();
    logic [3:0] tbl [4];
    tbl = '{4'h3, 4'h4, 4'hF, 4'($urandom_range(0, 15))};
    return tbl[$urandom_range(0, 3)];
  endfunction

  initial begin
    clr();
    rst = 1;
    model_reset();
    #1;
    chk_all("reset_async");
    @(negedge clk);
    repeat (2) tick();
    rst = 0;
    repeat (3) cyc("idle");
    start = 1;
    cyc("start");
    start = 0;
    #1;
    chk("run_after_start", run_state, 2'b01);

    // load-use, then the same with RNONE destination
    clr(); E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
    #1;
    chk("lu_ctl", {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc}, 7'b1101000);
    cyc("lu");
    clr(); E_icode = 4'h5; E_dstM = 4'hF; d_srcA = 4'hF; d_srcB = 4'hF;
    cyc("lu_rnone");

    // ret together with load-use, then ret alone
    clr(); D_icode = 4'h9; E_icode = 4'hB; E_dstM = 4'h4; d_srcB = 4'h4;
    cyc("ret_lu");
    E_icode = 4'h0;
    cyc("ret_only");

    // mispredict together with ret
    clr(); E_icode = 4'h7; e_Cnd = 0; D_icode = 4'h9;
    #1;
    chk("mp_ret_ctl", {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc}, 7'b1011000);
    cyc("mp_ret");

    // exception in M then W, halting
    clr(); E_icode = 4'h6; m_stat = 2'b10;
    cyc("exc_m");
    m_stat = 2'b00; W_stat = 2'b10;
    cyc("exc_w");
    clr();
    #1;
    chk("halt_state", {run_state, halted, halt_code}, {2'b10, 1'b1, 2'b10});
    start = 1;
    cyc("halt_start");
    start = 0;
    cyc("halted_hold");

    // reset while halted takes effect without a clock edge
    rst = 1;
    model_reset();
    cyc("rst_halted");
    rst = 0;

    // start coinciding with a W exception while idle only enters RUN
    start = 1; W_stat = 2'b01;
    cyc("start_exc_idle");
    clr();
    #1;
    chk("run_not_halt", run_state, 2'b01);

    // long run drives the cycle counter into saturation
    repeat (20) cyc("sat");
`ifdef PIPE_PERF_CNT_EN
    chk("cycle_cnt_sat", cycle_cnt, 4'hF);
`endif

    // randomized traffic against the model, with restarts after halts and stray resets
    for (int i = 0; i < 500; i++) begin
      D_icode = pick_icode(); E_icode = pick_icode(); M_icode = pick_icode();
      d_srcA = pick_reg(); d_srcB = pick_reg(); E_dstM = pick_reg();
      e_Cnd = 1'($urandom_range(0, 1));
      m_stat = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      W_stat = ($urandom_range(0, 29) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      start = (m_mode != 1) ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 99) == 0 || (m_mode == 2 && $urandom_range(0, 3) == 0)) begin
        rst = 1;
        model_reset();
      end else begin
        rst = 0;
      end
      cyc("rand");
    end
    rst = 0;
    clr();
    #1;
    chk_all("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline control unit for the Y86-64 PIPE processor.
- Each cycle it generates the stall and bubble controls for the F, D, E, M and W stage registers, covering load-use hazards, ret, mispredicted jumps and exceptions. It also gates condition-code updates.
- A run-state FSM (IDLE/RUN/HALTED) sequences processor start and freezes the pipeline after a non-AOK status retires.
- Optional saturating performance counters record hazard events.

Parameters:
- CNT_W, 32, width of each performance counter.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse; moves IDLE to RUN.
- D_icode  input  4  icode in the D register.
- d_srcA  input  4  decode srcA; 4'hF = RNONE.
- d_srcB  input  4  decode srcB; 4'hF = RNONE.
- E_icode  input  4  icode in the E register.
- E_dstM  input  4  dstM in the E register.
- e_Cnd  input  1  execute-stage condition result.
- M_icode  input  4  icode in the M register.
- m_stat  input  2  memory-stage status.
- W_stat  input  2  writeback status.
- F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall  output  1 each  stage-register controls.
- set_cc  output  1  condition-code write enable.
- run_state  output  2  00 IDLE, 01 RUN, 10 HALTED.
- halted  output  1  high when run_state is HALTED.
- halt_code  output  2  W_stat value latched on halt.
- cycle_cnt, loaduse_cnt, mispred_cnt, ret_cnt  output  CNT_W each  performance counters.

Behaviour:
- Encodings:
  - Status: AOK=00, HLT=01, ADR=10, INS=11. "exc(x)" means x != 00.
  - Icodes: IRRMOVQ=2, IMRMOVQ=5, IOPQ=6, IJXX=7, IRET=9, IPOPQ=B. RNONE=F.
- Combinational terms:
  - lu = (E_icode==IMRMOVQ or E_icode==IPOPQ) and E_dstM!=RNONE and (E_dstM==d_srcA or E_dstM==d_srcB).
  - rt = IRET in {D_icode, E_icode, M_icode}.
  - mp = E_icode==IJXX and !e_Cnd.
- RUN outputs (combinational, same cycle):
  - F_stall = lu | rt.
  - D_stall = lu.
  - D_bubble = mp | (!lu & rt).
  - E_bubble = mp | lu.
  - M_bubble = exc(m_stat) | exc(W_stat).
  - W_stall = exc(W_stat).
  - set_cc = E_icode==IOPQ & !exc(m_stat) & !exc(W_stat).
- IDLE outputs: F_stall=1, D_bubble=1, E_bubble=1, M_bubble=1. All other controls 0.
- HALTED outputs: F_stall=1, D_stall=1, E_bubble=1, M_bubble=1, W_stall=1. D_bubble=0, set_cc=0.
- The FSM only changes which values drive the outputs; RUN equations are never registered.
- FSM transitions:
  - IDLE->RUN on the posedge where start=1.
  - RUN->HALTED on the posedge where exc(W_stat); halt_code <= W_stat on that same edge.
  - HALTED is terminal; only rst leaves it.
  - start is ignored in RUN and HALTED.
- Reset: asynchronous and active-high; applies immediately, including mid-RUN or in HALTED. It sets run_state=IDLE, halted=0, halt_code=00 and all counters to 0. With rst asserted, outputs take their IDLE values.
- Simultaneous events:
  - lu and rt: the load-use response wins, so D_stall=1, D_bubble=0, E_bubble=1.
  - mp and rt: D_bubble=1, E_bubble=1, F_stall=1.
  - start in the same cycle as exc(W_stat) while IDLE: goes to RUN only; no halt is taken from IDLE.
  - E_dstM==RNONE never produces lu, even when d_srcA or d_srcB is also RNONE.

Optional Feature:
- Macro PIPE_PERF_CNT_EN.
- Defined: counters update on posedge, in RUN only, with one-cycle latency:
  - cycle_cnt +1 every RUN cycle.
  - loaduse_cnt +1 when lu.
  - mispred_cnt +1 when mp.
  - ret_cnt +1 when rt & !lu.
  - Each counter saturates at all-ones and never wraps.
  - The cycle of the RUN->HALTED transition is counted; HALTED cycles are not.
- Undefined: all four counter outputs are tied to 0 and no counter flops exist.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then 3 idle cycles -> run_state=00, F_stall=1, D_bubble=E_bubble=M_bubble=1, counters 0. start pulse -> run_state=01 on the next edge.
- Load-use: RUN, E_icode=5, E_dstM=3, d_srcA=3 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0. With E_dstM=F instead -> all controls 0. With the macro defined, loaduse_cnt=1 after the first case.
- Ret plus load-use: D_icode=9, E_icode=B, E_dstM=4, d_srcB=4 -> D_stall=1, D_bubble=0. Next cycle E_icode=0 with D_icode=9 still -> F_stall=1, D_bubble=1.
- Mispredict plus ret: E_icode=7, e_Cnd=0, D_icode=9 -> D_bubble=1, E_bubble=1, F_stall=1. mispred_cnt +1.
- Exception halt: m_stat=10 -> M_bubble=1, set_cc=0 with E_icode=6. Next cycle W_stat=10 -> W_stall=1; after the edge run_state=10, halted=1, halt_code=10. A later start has no effect. rst mid-HALTED -> IDLE with counters cleared.
- Saturation (CNT_W=4, macro defined): 20 RUN cycles -> cycle_cnt holds 4'hF.
